// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, state encoding
// and default bus widths.
package axi4_lite_pkg;
    localparam int DEFAULT_ADDRESS    = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } master_state_t;
endpackage

// File: rtl/axi4_lite_timeout_counter.sv
// Wait-state cycle counter; expired flags the TIMEOUT-th consecutive enabled
// cycle so the abort decision lands in that same cycle.
module axi4_lite_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == LAST);
endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI read or
// write and returns the read data and response code.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// WR_REQ     | AWVALID/WVALID pending, each drops on its own handshake
// WR_RESP    | BREADY high, waiting for BVALID
// RD_REQ     | ARVALID high, waiting for ARREADY
// RD_DATA    | RREADY high, waiting for RVALID
// RSP        | rsp_valid high until rsp_ready
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS    = DEFAULT_ADDRESS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDRESS-1:0]        M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDRESS-1:0]        M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);
    master_state_t state, state_next;

    logic                    aw_d, w_d, b_d, ar_d, r_d, rv_d, cr_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [1:0]              resp_d;
    logic                    latch, abort, expired, in_wait;
    logic [ADDRESS-1:0]      addr_q;

    assign in_wait = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                     (state == ST_RD_REQ) || (state == ST_RD_DATA);

    axi4_lite_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (ACLK),
        .rst     (ARESET),
        .clear   (state_next != state),
        .enable  (in_wait),
        .expired (expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        aw_d       = M_AWVALID;
        w_d        = M_WVALID;
        b_d        = M_BREADY;
        ar_d       = M_ARVALID;
        r_d        = M_RREADY;
        rv_d       = rsp_valid;
        rdata_d    = rsp_rdata;
        resp_d     = rsp_resp;
        latch      = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    latch = 1'b1;
                    if (cmd_write) begin
                        state_next = ST_WR_REQ;
                        aw_d       = 1'b1;
                        w_d        = 1'b1;
                    end else begin
                        state_next = ST_RD_REQ;
                        ar_d       = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                aw_d = M_AWVALID && !M_AWREADY;
                w_d  = M_WVALID && !M_WREADY;
                if (!aw_d && !w_d) begin
                    state_next = ST_WR_RESP;
                    b_d        = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (M_BVALID) begin
                    state_next = ST_RSP;
                    b_d        = 1'b0;
                    rv_d       = 1'b1;
                    rdata_d    = '0;
                    resp_d     = M_BRESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (M_ARREADY) begin
                    state_next = ST_RD_DATA;
                    ar_d       = 1'b0;
                    r_d        = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (M_RVALID) begin
                    state_next = ST_RSP;
                    r_d        = 1'b0;
                    rv_d       = 1'b1;
                    rdata_d    = M_RDATA;
                    resp_d     = M_RRESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                    rv_d       = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A handshake in the expiry cycle never reaches here, so it wins.
        if (abort) begin
            state_next = ST_RSP;
            aw_d       = 1'b0;
            w_d        = 1'b0;
            b_d        = 1'b0;
            ar_d       = 1'b0;
            r_d        = 1'b0;
            rv_d       = 1'b1;
            rdata_d    = '0;
            resp_d     = DECERR;
        end
        cr_d = (state_next == ST_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
            addr_q    <= '0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
        end else begin
            cmd_ready <= cr_d;
            rsp_valid <= rv_d;
            rsp_rdata <= rdata_d;
            rsp_resp  <= resp_d;
            M_AWVALID <= aw_d;
            M_WVALID  <= w_d;
            M_BREADY  <= b_d;
            M_ARVALID <= ar_d;
            M_RREADY  <= r_d;
            if (latch) begin
                addr_q  <= cmd_addr;
                M_WDATA <= cmd_wdata;
                M_WSTRB <= cmd_wstrb;
            end
        end
    end

    assign M_AWADDR = addr_q;
    assign M_ARADDR = addr_q;
endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master that converts a simple command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of `axi4_lite_slave`, driving that block's `S_*` channels from a testbench, CPU stub or DMA sequencer. It also returns each completed transaction's read data and response code.

## Interface
- `ADDRESS`, 32, address width of command and AXI address channels.
- `DATA_WIDTH`, 32, data width; the `cmd_wstrb` width is `DATA_WIDTH/8`.
- `TIMEOUT`, 255, maximum cycles spent in any AXI wait state before abort; must be ≥1.

Ports:
- `ACLK`  in  1  single clock; all logic is rising-edge.
- `ARESET`  in  1  reset; synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDRESS  byte address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `cmd_wstrb`  in  DATA_WIDTH/8  write strobes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  AXI response code, or DECERR on timeout.
- `M_AWADDR`, `M_AWVALID`, `M_AWREADY`, `M_WDATA`, `M_WSTRB`, `M_WVALID`, `M_WREADY`, `M_BRESP`, `M_BVALID`, `M_BREADY`, `M_ARADDR`, `M_ARVALID`, `M_ARREADY`, `M_RDATA`, `M_RRESP`, `M_RVALID`, `M_RREADY`: the standard AXI4-Lite master side, with widths matching `axi4_lite_slave`.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: `cmd_ready`=1. On accept, the block latches addr, wdata and wstrb, then moves to WR_REQ if `cmd_write`, otherwise to RD_REQ.
- WR_REQ: `M_AWVALID` and `M_WVALID` assert together.
  - Each valid drops independently on its own handshake (AW before W, W before AW, or both in the same cycle).
  - When both handshakes are done, the block moves to WR_RESP.
- WR_RESP: `M_BREADY`=1. On `M_BVALID`, the block captures `M_BRESP`, sets `rsp_rdata`=0 and moves to RSP.
- RD_REQ: `M_ARVALID`=1. On `M_ARREADY`, the block moves to RD_DATA.
- RD_DATA: `M_RREADY`=1. On `M_RVALID`, the block captures `M_RDATA` and `M_RRESP`, then moves to RSP.
- RSP: `rsp_valid`=1 with stable data. On `rsp_ready`, the block returns to IDLE.
- All `M_*VALID`, `M_*READY` and `rsp_*` outputs are registered. Address and data outputs come from the latched command.
- Timeout:
  - A counter clears on every state change and increments each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - When the counter reaches `TIMEOUT`, all master valid/ready outputs drop, `rsp_resp`=2'b11, `rsp_rdata`=0, and the block enters RSP.
  - A handshake in the same cycle as the timeout wins; the timeout is ignored.
- Only one transaction is outstanding at a time. `cmd_ready`=0 outside IDLE.

## Timing
- Reset:
  - All outputs are 0.
  - State returns to IDLE and the counter clears.
  - `cmd_ready` becomes 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts the transaction immediately; no response is produced.
- Accept at cycle N → `M_AWVALID`/`M_WVALID` (or `M_ARVALID`) high at N+1.
- `M_BVALID` (or `M_RVALID`) sampled at cycle M → `rsp_valid` high at M+1.
- Against `axi4_lite_slave`:
  - Write: accept at 0, AW/W handshake at 2, B handshake at 3, `rsp_valid` at 4.
  - Read: AR handshake at 2, R handshake at 3, `rsp_valid` at 4.
- After the `rsp_valid & rsp_ready` handshake, `cmd_ready` is high in the next cycle. Minimum command spacing is 5 cycles.

## Structure
- Shared package `axi4_lite_pkg` holds:
  - response constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - the master state encoding;
  - defaults for `ADDRESS` and `DATA_WIDTH`.
- One sub-module: `axi4_lite_timeout_counter`.
  - Inputs: clear, enable.
  - Output: `expired`.
  - Width: `$clog2(TIMEOUT+1)`.

## Test plan
- Write `cmd_addr`=0x0000_0008, `cmd_wdata`=0xDEAD_BEEF to `axi4_lite_slave` → `M_AWADDR`=0x8, `M_WDATA`=0xDEAD_BEEF; `rsp_resp`=00 and `rsp_rdata`=0 at cycle 4.
- Read back 0x8 → `M_ARADDR`=0x8, `rsp_rdata`=0xDEAD_BEEF, `rsp_resp`=00.
- Slave model asserting AWREADY 3 cycles before WREADY → AWVALID drops after its handshake while WVALID stays high; a single response with `rsp_resp`=00.
- Slave that never asserts ARREADY, `TIMEOUT`=10 → ARVALID drops after 10 cycles; `rsp_resp`=2'b11, `rsp_rdata`=0.
- `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_rdata` stable and `cmd_ready`=0 throughout; 1 cycle after release, `cmd_ready`=1.
- `ARESET` pulsed during WR_RESP → all outputs 0 the next cycle; no `rsp_valid`; the next write completes normally.
